// File: rtl/llsc_reservation_unit.sv
// llsc_reservation_unit: multi-channel LL/SC reservation tracker.
// Each channel holds a valid bit, a reserved granule and an optional expiry
// counter. SC results are registered and come out one cycle after the SC.
module llsc_reservation_unit #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int GRAN_LSB = 2,
  parameter int TIMEOUT  = 0,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] flush,
  input  logic              ll_valid,
  input  logic [CH_W-1:0]   ll_ch,
  input  logic [ADDR_W-1:0] ll_addr,
  input  logic              sc_valid,
  input  logic [CH_W-1:0]   sc_ch,
  input  logic [ADDR_W-1:0] sc_addr,
  input  logic              st_valid,
  input  logic [CH_W-1:0]   st_ch,
  input  logic [ADDR_W-1:0] st_addr,
  output logic              sc_done,
  output logic              sc_ok,
  output logic [NUM_CH-1:0] llbit_o
);

  localparam int GW = ADDR_W - GRAN_LSB;

  logic [NUM_CH-1:0] valid_q, valid_d;
  logic [GW-1:0]     gran_q [NUM_CH];
  logic [GW-1:0]     gran_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic              sc_done_q, sc_done_d;
  logic              sc_ok_q, sc_ok_d;

  logic [GW-1:0] ll_gran, sc_gran, st_gran;
  logic          st_in_range;
  logic          sc_hit;
  logic          foreign_st;

  assign ll_gran = ll_addr[ADDR_W-1:GRAN_LSB];
  assign sc_gran = sc_addr[ADDR_W-1:GRAN_LSB];
  assign st_gran = st_addr[ADDR_W-1:GRAN_LSB];

  // A store from a channel index that does not exist is ignored everywhere.
  assign st_in_range = (int'(st_ch) < NUM_CH);

  // Byte-offset bits inside a granule never take part in matching.
  generate
    if (GRAN_LSB > 0) begin : g_unused_low
      logic unused_low;
      assign unused_low = ^{ll_addr[GRAN_LSB-1:0], sc_addr[GRAN_LSB-1:0],
                            st_addr[GRAN_LSB-1:0]};
    end
  endgenerate

  // SC outcome from the current registered state. A same-cycle foreign store
  // to the granule is ordered first, so it makes the SC fail.
  always_comb begin
    sc_hit = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sc_ch == CH_W'(c)) begin
        sc_hit = valid_q[c] && (gran_q[c] == sc_gran) && !flush[c];
      end
    end
    foreign_st = st_valid && st_in_range && (st_ch != sc_ch) && (st_gran == sc_gran);
    sc_done_d  = sc_valid;
    sc_ok_d    = sc_valid && sc_hit && !foreign_st;
  end

  // Per-channel next state: flush, own SC, own LL, foreign store, expiry.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      valid_d[c] = valid_q[c];
      gran_d[c]  = gran_q[c];
      cnt_d[c]   = cnt_q[c];
      if (flush[c]) begin
        valid_d[c] = 1'b0;
      end else if (sc_valid && (sc_ch == CH_W'(c))) begin
        valid_d[c] = 1'b0;
      end else if (ll_valid && (ll_ch == CH_W'(c))) begin
        valid_d[c] = 1'b1;
        gran_d[c]  = ll_gran;
        cnt_d[c]   = CNT_W'(TIMEOUT);
      end else if (st_valid && st_in_range && (st_ch != CH_W'(c)) &&
                   valid_q[c] && (gran_q[c] == st_gran)) begin
        valid_d[c] = 1'b0;
      end else if ((TIMEOUT > 0) && valid_q[c]) begin
        if (cnt_q[c] == CNT_W'(1)) begin
          valid_d[c] = 1'b0;
        end else if (cnt_q[c] != '0) begin
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
        end
      end
    end
  end

  // State registers; reset clears reservations and any pending SC result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      sc_done_q <= 1'b0;
      sc_ok_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        gran_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      sc_done_q <= sc_done_d;
      sc_ok_q   <= sc_ok_d;
      for (int c = 0; c < NUM_CH; c++) begin
        gran_q[c] <= gran_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
    end
  end

  assign sc_done = sc_done_q;
  assign sc_ok   = sc_ok_q;
  assign llbit_o = valid_q;

endmodule

// File: doc/llsc_reservation_unit.md
Name: llsc_reservation_unit

Overview:
- Multi-channel successor to the single LLbit register.
- Holds one LL/SC reservation per hardware channel (thread/core): a valid bit, the reserved granule address and an expiry counter.
- Resolves SC success with a registered result and invalidates reservations on conflicting stores from other channels, on per-channel flush, and on timeout.
- Sits beside the MEM/WB stage and feeds the per-channel LLbit back to the pipeline.

Parameters:
- NUM_CH, 2, number of independent reservation channels (>=1).
- ADDR_W, 32, physical address width.
- GRAN_LSB, 2, low address bits ignored when matching; granule = 2^GRAN_LSB bytes.
- TIMEOUT, 0, cycles a reservation survives without SC; 0 disables expiry.
- CH_W, $clog2(NUM_CH) (min 1), channel index width (derived).
- CNT_W, $clog2(TIMEOUT+1) (min 1), expiry counter width (derived).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  NUM_CH  per-channel exception flush; clears that channel's reservation.
- ll_valid  in  1  LL executed this cycle.
- ll_ch  in  CH_W  channel issuing LL.
- ll_addr  in  ADDR_W  LL address.
- sc_valid  in  1  SC executed this cycle.
- sc_ch  in  CH_W  channel issuing SC.
- sc_addr  in  ADDR_W  SC address.
- st_valid  in  1  any committed store, SC write included, visible to all channels.
- st_ch  in  CH_W  channel performing the store.
- st_addr  in  ADDR_W  store address.
- sc_done  out  1  registered pulse, one cycle after sc_valid.
- sc_ok  out  1  SC result, valid while sc_done=1; 0 otherwise.
- llbit_o  out  NUM_CH  per-channel reservation valid bit, registered.

Behaviour:
- Reset (asynchronous, immediate):
  - llbit_o = 0, sc_done = 0, sc_ok = 0.
  - All reserved addresses = 0; all counters = 0.
- Match rule: addr[ADDR_W-1:GRAN_LSB] equals the stored granule.
- SC evaluation uses the registered state at the sc_valid cycle. ok is 1 iff all of the following hold:
  - llbit_o[sc_ch] = 1;
  - the granule matches sc_addr;
  - flush[sc_ch] = 0;
  - no st_valid from a channel other than sc_ch to the same granule in the same cycle. The concurrent foreign store is ordered first, so the SC fails.
- SC result: sc_done <= 1 and sc_ok <= ok on the next edge; both return to 0 the following cycle unless another SC arrives.
- Back-to-back SCs produce back-to-back results.
- Per-channel next state, highest priority first:
  1. flush[c]=1: valid <= 0.
  2. sc_valid and sc_ch==c: valid <= 0, regardless of success.
  3. ll_valid and ll_ch==c: valid <= 1, addr <= ll_addr granule, cnt <= TIMEOUT.
  4. st_valid, st_ch!=c, valid and granule matches: valid <= 0.
  5. TIMEOUT>0, valid and cnt==1: valid <= 0. Otherwise, if valid and cnt>0: cnt <= cnt-1.
  6. Otherwise hold.
- Consequences of the priority order:
  - LL and SC on the same channel in the same cycle: SC result comes from the old state, then the reservation clears, because rule 2 outranks rule 3.
  - LL on channel c plus a foreign store to the same granule in the same cycle: the LL reservation is set (store ordered before the LL).
- Stores by the owning channel (st_ch==c) never clear channel c's reservation.
- The SC write itself, presented on st_valid, clears matching reservations on other channels.
- Expiry: with TIMEOUT=N, a reservation set by LL at edge k is cleared at edge k+N if untouched. The SC must arrive before that edge to succeed.
- With TIMEOUT=0 the counter logic is tied off and reservations never expire.
- Out-of-range channel index (>= NUM_CH) is ignored for LL, SC and store. An SC on such an index still produces sc_done with sc_ok=0.
- Reset asserted mid-operation clears everything immediately. A pending SC result is dropped, and sc_done stays 0 until an SC is issued after reset release.

Test Plan:
- LL ch0 @0x1000, SC ch0 @0x1000 two cycles later -> sc_done=1, sc_ok=1 one cycle after SC; llbit_o[0]=0 afterwards.
- LL ch0 @0x1000, store ch1 @0x1002 (same granule, GRAN_LSB=2), then SC ch0 @0x1000 -> sc_ok=0. Repeat with store ch0 @0x1000 -> sc_ok=1.
- LL ch1 @0x2000, flush[1]=1 the next cycle, SC ch1 @0x2000 -> llbit_o[1]=0 after flush, sc_ok=0. llbit_o[0] is unaffected.
- TIMEOUT=4: LL ch0 @0x40 at edge k -> llbit_o[0]=1 through k+3 and 0 at k+4. SC at k+3 -> sc_ok=1; SC at k+4 -> sc_ok=0.
- Same cycle: SC ch0 @0x80 with valid reservation, plus store ch1 @0x80 -> sc_ok=0. Same cycle: LL ch1 @0x80 plus store ch0 @0x80 -> llbit_o[1]=1.
- rst pulsed asynchronously, between edges, during the cycle after an SC -> sc_done, sc_ok and all llbit_o drop to 0 immediately, without waiting for a clock edge; no result pulse appears after release.
